// File: rtl/pool_frame_sequencer.sv
// Frame sequencer for the 2x2 row-pair max-pool/ReLU stage: streams C channels of WxH pixels
// from the feature RAM and collects the pooled results. `POOL_SEQ_PERF_EN adds the cyc_cnt port.
module pool_frame_sequencer #(
    parameter int In_d_W = 32,
    parameter int W      = 26,
    parameter int H      = 26,
    parameter int C      = 8,
    parameter int ADDR_W = 16,
    parameter int TMO    = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [In_d_W-1:0] mem_rd_data,
    output logic              pool_clr,
    output logic              pool_in_valid,
    output logic [In_d_W-1:0] pool_in_data,
    input  logic              pool_out_valid,
    input  logic [In_d_W-1:0] pool_out_data,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic [In_d_W-1:0] res_wr_data
`ifdef POOL_SEQ_PERF_EN
    ,
    output logic [31:0]       cyc_cnt
`endif
);

    localparam int TW = $clog2(TMO + 1);
    localparam logic [ADDR_W-1:0] NPIX_LAST = ADDR_W'(W * H - 1);
    localparam logic [ADDR_W-1:0] NOUT      = ADDR_W'((W / 2) * (H / 2));
    localparam logic [ADDR_W-1:0] CH_LAST   = ADDR_W'(C - 1);
    localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
    localparam logic [TW-1:0]     TMO_LAST  = TW'(TMO - 1);
    localparam logic [TW-1:0]     T_ONE     = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pix_cnt;
    logic [ADDR_W-1:0] out_cnt;
    logic [ADDR_W-1:0] ch;
    logic [ADDR_W-1:0] res_base;
    logic [TW-1:0]     tmo_cnt;
    logic              start_acc;
    logic              counting;
    logic              out_full;
    logic              tmo_hit;
    logic              drain_exit;

    assign start_acc = (state == S_IDLE) && start;
    assign counting  = (state == S_STREAM) || (state == S_DRAIN);
    assign out_full  = (out_cnt == NOUT);
    assign tmo_hit   = (state == S_DRAIN) && !pool_out_valid && !out_full && (tmo_cnt == TMO_LAST);

    // Pixel bus is forced to zero outside valid pixels so it reads 0 in reset and idle.
    assign pool_in_data = pool_in_valid ? mem_rd_data : '0;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b1;
        done       = 1'b0;
        pool_clr   = 1'b0;
        mem_rd_en  = 1'b0;
        drain_exit = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_CLR;
            end
            S_CLR: begin
                pool_clr = 1'b1;
                state_nx = S_STREAM;
            end
            S_STREAM: begin
                mem_rd_en = 1'b1;
                if (pix_cnt == NPIX_LAST) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_full || tmo_hit) begin
                    drain_exit = 1'b1;
                    state_nx   = (ch == CH_LAST) ? S_DONE : S_CLR;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mem_rd_addr   <= '0;
            pix_cnt       <= '0;
            out_cnt       <= '0;
            ch            <= '0;
            res_base      <= '0;
            tmo_cnt       <= '0;
            err           <= 1'b0;
            pool_in_valid <= 1'b0;
            res_wr_en     <= 1'b0;
            res_wr_addr   <= '0;
            res_wr_data   <= '0;
        end else begin
            pool_in_valid <= mem_rd_en;
            res_wr_en     <= 1'b0;
            if (start_acc) begin
                mem_rd_addr <= '0;
                ch          <= '0;
                res_base    <= '0;
                err         <= 1'b0;
            end
            if (state == S_CLR) begin
                pix_cnt <= '0;
                out_cnt <= '0;
            end
            // The read address runs linearly across channels, so it equals ch*W*H + pixel.
            if (mem_rd_en) begin
                mem_rd_addr <= mem_rd_addr + A_ONE;
                pix_cnt     <= pix_cnt + A_ONE;
            end
            if (counting && pool_out_valid) begin
                if (out_full) begin
                    err <= 1'b1;
                end else begin
                    res_wr_en   <= 1'b1;
                    res_wr_addr <= res_base + out_cnt;
                    res_wr_data <= pool_out_data;
                    out_cnt     <= out_cnt + A_ONE;
                end
            end
            tmo_cnt <= ((state == S_DRAIN) && !pool_out_valid && !out_full) ? tmo_cnt + T_ONE : '0;
            if (tmo_hit) err <= 1'b1;
            if (drain_exit && (ch != CH_LAST)) begin
                ch       <= ch + A_ONE;
                res_base <= res_base + NOUT;
            end
        end
    end

`ifdef POOL_SEQ_PERF_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cyc_cnt <= '0;
        end else if (start_acc) begin
            cyc_cnt <= '0;
        end else if (busy) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pool_frame_sequencer.sv
// Directed bench for pool_frame_sequencer: a C=1 and a C=2 instance (W=H=4) with a RAM model
// and a behavioural 2x2 max-pool/ReLU model.
module tb_pool_frame_sequencer;

    localparam int DW = 32;
    localparam int AW = 16;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    logic          start_s   [2];
    logic          arm       [2];
    logic          busy_w    [2];
    logic          done_w    [2];
    logic          err_w     [2];
    logic          rd_en_w   [2];
    logic          pclr_w    [2];
    logic          piv_w     [2];
    logic          wr_en_w   [2];
    logic          pov       [2];
    logic [AW-1:0] rd_addr_w [2];
    logic [AW-1:0] wr_addr_w [2];
    logic [DW-1:0] rdata     [2];
    logic [DW-1:0] pin_w     [2];
    logic [DW-1:0] wr_data_w [2];
    logic [DW-1:0] pod       [2];
    logic          suppress;
`ifdef POOL_SEQ_PERF_EN
    logic [31:0]   cyc_w     [2];
`endif

    pool_frame_sequencer #(.In_d_W(DW), .W(4), .H(4), .C(1), .ADDR_W(AW), .TMO(8)) u_c1 (
        .clk(clk), .clr_n(clr_n), .start(start_s[0]),
        .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]),
        .mem_rd_en(rd_en_w[0]), .mem_rd_addr(rd_addr_w[0]), .mem_rd_data(rdata[0]),
        .pool_clr(pclr_w[0]), .pool_in_valid(piv_w[0]), .pool_in_data(pin_w[0]),
        .pool_out_valid(pov[0]), .pool_out_data(pod[0]),
        .res_wr_en(wr_en_w[0]), .res_wr_addr(wr_addr_w[0]), .res_wr_data(wr_data_w[0])
`ifdef POOL_SEQ_PERF_EN
        , .cyc_cnt(cyc_w[0])
`endif
    );

    pool_frame_sequencer #(.In_d_W(DW), .W(4), .H(4), .C(2), .ADDR_W(AW), .TMO(8)) u_c2 (
        .clk(clk), .clr_n(clr_n), .start(start_s[1]),
        .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]),
        .mem_rd_en(rd_en_w[1]), .mem_rd_addr(rd_addr_w[1]), .mem_rd_data(rdata[1]),
        .pool_clr(pclr_w[1]), .pool_in_valid(piv_w[1]), .pool_in_data(pin_w[1]),
        .pool_out_valid(pov[1]), .pool_out_data(pod[1]),
        .res_wr_en(wr_en_w[1]), .res_wr_addr(wr_addr_w[1]), .res_wr_data(wr_data_w[1])
`ifdef POOL_SEQ_PERF_EN
        , .cyc_cnt(cyc_w[1])
`endif
    );

    // Feature RAM: one cycle read latency.
    logic [DW-1:0] ram [2][32];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rd_en_w[d]) rdata[d] <= ram[d][rd_addr_w[d][4:0]];
        end
    end

    // Pool-stage model: row-major 4x4 input, one registered output per completed 2x2 block.
    logic signed [DW-1:0] first_v [2];
    logic signed [DW-1:0] lbuf    [2][2];
    logic signed [DW-1:0] pair_v  [2];
    logic signed [DW-1:0] quad_v  [2];
    int unsigned          pcol    [2];
    int unsigned          prow    [2];

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            pair_v[d] = ($signed(pin_w[d]) > first_v[d]) ? $signed(pin_w[d]) : first_v[d];
            quad_v[d] = (pair_v[d] > lbuf[d][pcol[d] / 2]) ? pair_v[d] : lbuf[d][pcol[d] / 2];
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pov[d] <= 1'b0;
            if (pclr_w[d]) begin
                pcol[d] <= 0;
                prow[d] <= 0;
            end else if (piv_w[d]) begin
                if (pcol[d] % 2 == 0) begin
                    first_v[d] <= $signed(pin_w[d]);
                end else if (prow[d] % 2 == 0) begin
                    lbuf[d][pcol[d] / 2] <= pair_v[d];
                end else begin
                    pov[d] <= !suppress;
                    pod[d] <= quad_v[d][DW-1] ? '0 : quad_v[d];
                end
                if (pcol[d] == 3) begin
                    pcol[d] <= 0;
                    prow[d] <= prow[d] + 1;
                end else begin
                    pcol[d] <= pcol[d] + 1;
                end
            end
        end
    end

    // Monitor: rel is the cycle number since the armed start (1 = cycle after start).
    int unsigned   rel      [2];
    int unsigned   done_cnt [2];
    int unsigned   done_cyc [2];
    int unsigned   clr_cnt  [2];
    int unsigned   rd_cnt   [2];
    int unsigned   wr_cnt   [2];
    int unsigned   wr_idx   [2];
    int unsigned   wr_cyc   [2][8];
    logic [DW-1:0] res      [2][8];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (start_s[d] && arm[d]) begin
                rel[d]    <= 1;
                wr_idx[d] <= 0;
            end else begin
                rel[d] <= rel[d] + 1;
            end
            if (done_w[d]) begin
                done_cnt[d] <= done_cnt[d] + 1;
                done_cyc[d] <= rel[d];
            end
            if (pclr_w[d])  clr_cnt[d] <= clr_cnt[d] + 1;
            if (rd_en_w[d]) rd_cnt[d]  <= rd_cnt[d] + 1;
            if (wr_en_w[d]) begin
                wr_cnt[d] <= wr_cnt[d] + 1;
                if (wr_addr_w[d] < 8) res[d][wr_addr_w[d][2:0]] <= wr_data_w[d];
                if (wr_idx[d] < 8) begin
                    wr_cyc[d][wr_idx[d]] <= rel[d];
                    wr_idx[d] <= wr_idx[d] + 1;
                end
            end
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int unsigned b_done, b_clr, b_rd, b_wr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap(input int d);
        b_done = done_cnt[d];
        b_clr  = clr_cnt[d];
        b_rd   = rd_cnt[d];
        b_wr   = wr_cnt[d];
    endtask

    task automatic pulse_start(input int d);
        start_s[d] = 1'b1;
        arm[d]     = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        arm[d]     = 1'b0;
    endtask

    task automatic wait_done(input int d, input int unsigned lim);
        int unsigned n = 0;
        while (done_w[d] !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("done_seen%0d", d), done_w[d], 1'b1);
        @(negedge clk);
    endtask

    task automatic run_frame(input int d);
        snap(d);
        pulse_start(d);
        wait_done(d, 200);
    endtask

    task automatic chk_idle_outputs(input int d, input string pfx);
        chk($sformatf("%s_busy%0d", pfx, d), busy_w[d], 1'b0);
        chk($sformatf("%s_done%0d", pfx, d), done_w[d], 1'b0);
        chk($sformatf("%s_err%0d", pfx, d), err_w[d], 1'b0);
        chk($sformatf("%s_rd_en%0d", pfx, d), rd_en_w[d], 1'b0);
        chk($sformatf("%s_rd_addr%0d", pfx, d), rd_addr_w[d], 0);
        chk($sformatf("%s_pclr%0d", pfx, d), pclr_w[d], 1'b0);
        chk($sformatf("%s_piv%0d", pfx, d), piv_w[d], 1'b0);
        chk($sformatf("%s_pin%0d", pfx, d), pin_w[d], 0);
        chk($sformatf("%s_wr_en%0d", pfx, d), wr_en_w[d], 1'b0);
        chk($sformatf("%s_wr_addr%0d", pfx, d), wr_addr_w[d], 0);
        chk($sformatf("%s_wr_data%0d", pfx, d), wr_data_w[d], 0);
    endtask

    initial begin
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        arm[0]     = 1'b0; arm[1]     = 1'b0;
        suppress   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ram[0][i] = 32'(i);
            ram[1][i] = (i < 16) ? 32'(i) : 32'(i - 16 + 100);
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle_outputs(0, "rst");
        chk_idle_outputs(1, "rst");
        clr_n = 1'b1;
        @(negedge clk);

        // C=1, ascending pixels 0..15
        run_frame(0);
        chk("t1_done_cyc", done_cyc[0], 21);
        chk("t1_res0", res[0][0], 5);
        chk("t1_res1", res[0][1], 7);
        chk("t1_res2", res[0][2], 13);
        chk("t1_res3", res[0][3], 15);
        chk("t1_wr_cyc0", wr_cyc[0][0], 10);
        chk("t1_wr_cyc1", wr_cyc[0][1], 12);
        chk("t1_wr_cyc2", wr_cyc[0][2], 18);
        chk("t1_wr_cyc3", wr_cyc[0][3], 20);
        chk("t1_err", err_w[0], 1'b0);
        chk("t1_busy_after", busy_w[0], 1'b0);
        chk("t1_n_done", done_cnt[0] - b_done, 1);
        chk("t1_n_clr", clr_cnt[0] - b_clr, 1);
        chk("t1_n_rd", rd_cnt[0] - b_rd, 16);
        chk("t1_n_wr", wr_cnt[0] - b_wr, 4);
`ifdef POOL_SEQ_PERF_EN
        chk("t1_cyc_cnt", cyc_w[0], 21);
`endif

        // C=1, negative pixels -> ReLU zeros; started in the cycle right after done
        for (int i = 0; i < 16; i++) ram[0][i] = 32'(i - 16);
        run_frame(0);
        chk("t2_done_cyc", done_cyc[0], 21);
        chk("t2_res0", res[0][0], 0);
        chk("t2_res1", res[0][1], 0);
        chk("t2_res2", res[0][2], 0);
        chk("t2_res3", res[0][3], 0);
        chk("t2_n_wr", wr_cnt[0] - b_wr, 4);

        // C=2 with a stray start pulse during STREAM
        snap(1);
        pulse_start(1);
        repeat (5) @(negedge clk);
        start_s[1] = 1'b1;
        @(negedge clk);
        start_s[1] = 1'b0;
        wait_done(1, 200);
        repeat (60) @(negedge clk);
        chk("t3_done_cyc", done_cyc[1], 41);
        chk("t3_n_done", done_cnt[1] - b_done, 1);
        chk("t3_n_clr", clr_cnt[1] - b_clr, 2);
        chk("t3_n_rd", rd_cnt[1] - b_rd, 32);
        chk("t3_n_wr", wr_cnt[1] - b_wr, 8);
        chk("t3_err", err_w[1], 1'b0);
        chk("t3_res0", res[1][0], 5);
        chk("t3_res1", res[1][1], 7);
        chk("t3_res2", res[1][2], 13);
        chk("t3_res3", res[1][3], 15);
        chk("t3_res4", res[1][4], 105);
        chk("t3_res5", res[1][5], 107);
        chk("t3_res6", res[1][6], 113);
        chk("t3_res7", res[1][7], 115);

        // Drain timeout: pool outputs suppressed
        suppress = 1'b1;
        run_frame(0);
        chk("t4_err", err_w[0], 1'b1);
        chk("t4_done_cyc", done_cyc[0], 26);
        chk("t4_n_done", done_cnt[0] - b_done, 1);
        chk("t4_n_wr", wr_cnt[0] - b_wr, 0);
        suppress = 1'b0;
        for (int i = 0; i < 16; i++) ram[0][i] = 32'(i);
        snap(0);
        pulse_start(0);
        chk("t4_err_cleared", err_w[0], 1'b0);
        wait_done(0, 200);
        chk("t4b_done_cyc", done_cyc[0], 21);
        chk("t4b_err", err_w[0], 1'b0);
        chk("t4b_res0", res[0][0], 5);
        chk("t4b_res3", res[0][3], 15);

        // Reset mid-STREAM on C=2
        for (int i = 0; i < 16; i++) begin
            ram[1][i]      = 32'(i + 200);
            ram[1][i + 16] = 32'(i + 300);
        end
        snap(1);
        pulse_start(1);
        repeat (4) @(negedge clk);
        chk("t5_in_stream", rd_en_w[1], 1'b1);
        clr_n = 1'b0;
        #1;
        chk_idle_outputs(1, "t5_rst");
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("t5_no_done", done_cnt[1] - b_done, 0);
        run_frame(1);
        chk("t5_done_cyc", done_cyc[1], 41);
        chk("t5_n_clr", clr_cnt[1] - b_clr, 2);
        chk("t5_n_rd", rd_cnt[1] - b_rd, 32);
        chk("t5_err", err_w[1], 1'b0);
        chk("t5_res0", res[1][0], 205);
        chk("t5_res1", res[1][1], 207);
        chk("t5_res2", res[1][2], 213);
        chk("t5_res3", res[1][3], 215);
        chk("t5_res4", res[1][4], 305);
        chk("t5_res5", res[1][5], 307);
        chk("t5_res6", res[1][6], 313);
        chk("t5_res7", res[1][7], 315);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
